// File: rtl/spectrum_pkg.sv
// spectrum_pkg: shared state type and default constants for the spectrum buffer
package spectrum_pkg;
    localparam int DEPTH_DEF = 512;
    localparam int BIN_W = $clog2(DEPTH_DEF);
    localparam logic [31:0] OOR_DATA = 32'hDEAD_BEEF;
    typedef enum logic {IDLE, CLEAR} state_e;
endpackage

// File: rtl/spectrum_buffer_slave_if.sv
// spectrum_buffer_slave_if: Avalon-MM bus bundle between a master and the spectrum buffer
interface spectrum_buffer_slave_if;
    logic [31:0] slave_address;
    logic        slave_read;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic [31:0] slave_readdata;
    logic        slave_readdatavalid;
    logic        slave_waitrequest;
    modport master (
        output slave_address, slave_read, slave_write, slave_writedata,
        input  slave_readdata, slave_readdatavalid, slave_waitrequest
    );
    modport slave (
        input  slave_address, slave_read, slave_write, slave_writedata,
        output slave_readdata, slave_readdatavalid, slave_waitrequest
    );
endinterface

// File: rtl/spectrum_ram.sv
// spectrum_ram: simple dual-port RAM with registered read, write data forwarded on address match
module spectrum_ram #(
    parameter int DEPTH = spectrum_pkg::DEPTH_DEF,
    parameter int AW    = spectrum_pkg::BIN_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q, rdata_d;
    always_comb rdata_d = (we && waddr == raddr) ? wdata : mem[raddr];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata_q <= rdata_d;
    end
    assign rdata = rdata_q;
endmodule

// File: rtl/spectrum_buffer_slave.sv
// spectrum_buffer_slave: Avalon-MM frame buffer with clear sweep, frame completion and peak tracking
module spectrum_buffer_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h7000,
    parameter int          DEPTH     = spectrum_pkg::DEPTH_DEF,
    parameter int          RD_LAT    = 2,
    parameter logic [31:0] OOR_DATA  = spectrum_pkg::OOR_DATA
) (
    input  logic                     clk,
    input  logic                     reset,
    spectrum_buffer_slave_if.slave   bus,
    input  logic                     clear_req,
    output logic                     clear_busy,
    output logic                     frame_done,
    output logic [31:0]              peak_value,
    output logic [$clog2(DEPTH)-1:0] peak_bin,
    output logic [$clog2(DEPTH):0]   write_count
);
    import spectrum_pkg::*;
    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);
    state_e        state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [31:0]   run_peak_q, run_peak_d, peak_value_q, peak_value_d;
    logic [AW-1:0] run_bin_q, run_bin_d, peak_bin_q, peak_bin_d;
    logic          frame_done_q, frame_done_d;
    logic          rd1_q, rd1_d, oor1_q, oor1_d;
    logic [RD_LAT-2:0] vld_q, vld_d;
    logic [31:0]   dat_q [RD_LAT-1];
    logic [31:0]   dat_d [RD_LAT-1];
    logic [31:0]   off, ram_wdata, ram_rdata;
    logic [AW-1:0] idx, ram_waddr;
    logic          in_range, wr_en, rd_en, ram_we, clearing, bigger;

    // Subtracting the base wraps addresses below it to large values, so one compare covers both bounds
    assign off       = bus.slave_address - BASE_ADDR;
    assign in_range  = off < SPAN;
    assign idx       = off[AW+1:2];
    assign clearing  = state_q == CLEAR;
    assign wr_en     = !clearing && bus.slave_write && in_range;
    assign rd_en     = !clearing && bus.slave_read && !bus.slave_write;
    assign ram_we    = clearing || wr_en;
    assign ram_waddr = clearing ? clr_idx_q : idx;
    assign ram_wdata = clearing ? '0 : bus.slave_writedata;
    assign bigger    = bus.slave_writedata > run_peak_q;

    spectrum_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (idx),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        cnt_d        = cnt_q;
        run_peak_d   = run_peak_q;
        run_bin_d    = run_bin_q;
        peak_value_d = peak_value_q;
        peak_bin_d   = peak_bin_q;
        frame_done_d = 1'b0;
        rd1_d        = rd_en;
        oor1_d       = !in_range;
        vld_d[0]     = rd1_q;
        dat_d[0]     = oor1_q ? OOR_DATA : ram_rdata;
        for (int i = 1; i < RD_LAT - 1; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
        if (clearing) begin
            clr_idx_d = clr_idx_q + AW'(1);
            if (clr_idx_q == AW'(DEPTH - 1)) begin
                state_d    = IDLE;
                cnt_d      = '0;
                run_peak_d = '0;
                run_bin_d  = '0;
            end
        end else begin
            if (clear_req) state_d = CLEAR;
            if (wr_en) begin
                run_peak_d = bigger ? bus.slave_writedata : run_peak_q;
                run_bin_d  = bigger ? idx : run_bin_q;
                cnt_d      = cnt_q + (AW+1)'(1);
                if (cnt_d == (AW+1)'(DEPTH)) begin
                    frame_done_d = 1'b1;
                    peak_value_d = run_peak_d;
                    peak_bin_d   = run_bin_d;
                    cnt_d        = '0;
                    run_peak_d   = '0;
                    run_bin_d    = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CLEAR;
            clr_idx_q    <= '0;
            cnt_q        <= '0;
            run_peak_q   <= '0;
            run_bin_q    <= '0;
            peak_value_q <= '0;
            peak_bin_q   <= '0;
            frame_done_q <= 1'b0;
            rd1_q        <= 1'b0;
            oor1_q       <= 1'b0;
            vld_q        <= '0;
            dat_q        <= '{default: '0};
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            cnt_q        <= cnt_d;
            run_peak_q   <= run_peak_d;
            run_bin_q    <= run_bin_d;
            peak_value_q <= peak_value_d;
            peak_bin_q   <= peak_bin_d;
            frame_done_q <= frame_done_d;
            rd1_q        <= rd1_d;
            oor1_q       <= oor1_d;
            vld_q        <= vld_d;
            dat_q        <= dat_d;
        end
    end

    assign bus.slave_waitrequest   = clearing;
    assign bus.slave_readdatavalid = vld_q[RD_LAT-2];
    assign bus.slave_readdata      = dat_q[RD_LAT-2];
    assign clear_busy  = clearing;
    assign frame_done  = frame_done_q;
    assign peak_value  = peak_value_q;
    assign peak_bin    = peak_bin_q;
    assign write_count = cnt_q;
endmodule

// File: tb/tb_spectrum_buffer_slave.sv
// tb_spectrum_buffer_slave: directed and random checks of the spectrum buffer against a transaction-level model
module tb_spectrum_buffer_slave;
    localparam int DEPTH = 512;
    localparam logic [31:0] BASE = 32'h7000;
    localparam logic [31:0] OOR = 32'hDEAD_BEEF;

    typedef struct { int bin; logic [31:0] val; } wr_t;
    typedef struct { int due; logic [31:0] data; } rd_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear_req = 1'b0;
    logic clear_busy, frame_done;
    logic [31:0] peak_value;
    logic [8:0]  peak_bin;
    logic [9:0]  write_count;

    int n_assert = 0;
    int n_fail = 0;
    int cyc_n = 0;
    int busy_left = 0;
    logic [31:0] mem_m [DEPTH];
    logic [31:0] exp_pv = '0;
    int exp_pb = 0;
    wr_t frame_q[$];
    rd_t rdq[$];

    always #5 clk = ~clk;

    spectrum_buffer_slave_if bus();

    spectrum_buffer_slave #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .RD_LAT    (2),
        .OOR_DATA  (OOR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .clear_req   (clear_req),
        .clear_busy  (clear_busy),
        .frame_done  (frame_done),
        .peak_value  (peak_value),
        .peak_bin    (peak_bin),
        .write_count (write_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d, input logic clr);
        bit busy;
        bit inr;
        bit fd;
        int bin;
        int best;
        busy = busy_left > 0;
        bus.slave_read = rd;
        bus.slave_write = wr;
        bus.slave_address = a;
        bus.slave_writedata = d;
        clear_req = clr;
        chk("waitrequest", 32'(bus.slave_waitrequest), 32'(busy));
        chk("clear_busy", 32'(clear_busy), 32'(busy));
        @(posedge clk);
        cyc_n++;
        fd = 1'b0;
        if (busy) begin
            busy_left--;
            if (busy_left == 0) frame_q.delete();
        end else begin
            inr = a >= BASE && a < BASE + 32'(4 * DEPTH);
            bin = inr ? int'((a - BASE) >> 2) : 0;
            if (wr && inr) begin
                mem_m[bin] = d;
                frame_q.push_back('{bin, d});
                if (frame_q.size() == DEPTH) begin
                    best = 0;
                    for (int k = 1; k < frame_q.size(); k++)
                        if (frame_q[k].val > frame_q[best].val) best = k;
                    exp_pv = frame_q[best].val;
                    exp_pb = frame_q[best].bin;
                    fd = 1'b1;
                    frame_q.delete();
                end
            end
            if (rd && !wr) rdq.push_back('{cyc_n + 1, inr ? mem_m[bin] : OOR});
            if (clr) begin
                busy_left = DEPTH;
                foreach (mem_m[k]) mem_m[k] = '0;
            end
        end
        #1;
        chk("frame_done", 32'(frame_done), 32'(fd));
        chk("peak_value", peak_value, exp_pv);
        chk("peak_bin", 32'(peak_bin), 32'(exp_pb));
        chk("write_count", 32'(write_count), 32'(frame_q.size()));
        if (rdq.size() > 0 && rdq[0].due == cyc_n) begin
            chk("readdatavalid", 32'(bus.slave_readdatavalid), 32'd1);
            chk("readdata", bus.slave_readdata, rdq[0].data);
            void'(rdq.pop_front());
        end else begin
            chk("readdatavalid", 32'(bus.slave_readdatavalid), 32'd0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        bus.slave_read = 1'b0;
        bus.slave_write = 1'b0;
        clear_req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        busy_left = DEPTH;
        frame_q.delete();
        rdq.delete();
        exp_pv = '0;
        exp_pb = 0;
        foreach (mem_m[k]) mem_m[k] = '0;
        chk("rst_readdata", bus.slave_readdata, 32'h0);
        chk("rst_readdatavalid", 32'(bus.slave_readdatavalid), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_peak_value", peak_value, 32'h0);
        chk("rst_peak_bin", 32'(peak_bin), 32'd0);
        chk("rst_write_count", 32'(write_count), 32'd0);
        chk("rst_waitrequest", 32'(bus.slave_waitrequest), 32'd1);
    endtask

    // Counts busy cycles while optionally holding a read, bounded so a stuck clear cannot hang the run
    task automatic wait_clear(input string tag, input logic hold_rd, input int clr_at);
        int w;
        w = 0;
        while (bus.slave_waitrequest && w < 600) begin
            cyc(hold_rd, 1'b0, BASE, 32'h0, w == clr_at);
            w++;
        end
        chk(tag, 32'(w), 32'(DEPTH));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        bus.slave_address = '0;
        bus.slave_read = 1'b0;
        bus.slave_write = 1'b0;
        bus.slave_writedata = '0;
        do_reset(3);
        wait_clear("clear_after_reset", 1'b1, -1);
        cyc(1'b1, 1'b0, BASE, 32'h0, 1'b0);
        idle(2);

        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, BASE + 32'(4 * i), 32'(i * 3), 1'b0);
        chk("frame1_done_pulse", 32'(frame_done), 32'd1);
        chk("frame1_peak_value", peak_value, 32'd1533);
        chk("frame1_peak_bin", 32'(peak_bin), 32'd511);
        chk("frame1_write_count", 32'(write_count), 32'd0);
        idle(1);
        chk("frame1_done_once", 32'(frame_done), 32'd0);

        for (int i = 0; i < DEPTH; i++)
            cyc(1'b0, 1'b1, BASE + 32'(4 * i), (i == 10 || i == 20) ? 32'h100 : $urandom_range(255, 0), 1'b0);
        chk("tie_peak_bin", 32'(peak_bin), 32'd10);
        chk("tie_peak_value", peak_value, 32'h100);
        for (int i = DEPTH - 1; i >= 0; i--)
            cyc(1'b0, 1'b1, BASE + 32'(4 * i), (i == 0) ? 32'd5 : $urandom_range(4, 0), 1'b0);
        chk("rev_peak_value", peak_value, 32'd5);
        chk("rev_peak_bin", 32'(peak_bin), 32'd0);

        cyc(1'b1, 1'b0, 32'h7000, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h7004, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h8000, 32'h0, 1'b0);
        idle(2);

        cyc(1'b0, 1'b1, 32'h7010, 32'hABCD, 1'b0);
        cyc(1'b1, 1'b0, 32'h7010, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 32'h6FFC, 32'h1234_5678, 1'b0);
        cyc(1'b1, 1'b0, BASE + 32'(4 * 511), 32'h0, 1'b0);
        cyc(1'b1, 1'b1, 32'h7020, 32'h55, 1'b0);
        cyc(1'b1, 1'b0, 32'h7020, 32'h0, 1'b0);
        idle(2);

        for (int i = 0; i < 600; i++) begin
            a = ($urandom_range(7, 0) == 0) ? 32'h8000 + 32'($urandom_range(15, 0))
                : BASE - 32'd8 + 32'(4 * $urandom_range(DEPTH + 3, 0)) + 32'($urandom_range(3, 0));
            cyc($urandom_range(2, 0) == 0, $urandom_range(1, 0) == 1, a, $urandom, 1'b0);
        end
        idle(2);

        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        wait_clear("clear_before_frame", 1'b0, -1);
        for (int i = 0; i < 100; i++)
            cyc(1'b0, 1'b1, BASE + 32'(4 * $urandom_range(DEPTH - 1, 0)), $urandom, 1'b0);
        chk("partial_write_count", 32'(write_count), 32'd100);
        cyc(1'b1, 1'b0, BASE + 32'(4 * 5), 32'h0, 1'b1);
        wait_clear("clear_with_read", 1'b0, -1);
        chk("post_clear_count", 32'(write_count), 32'd0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, BASE + 32'(4 * i), 32'h0, 1'b0);
        idle(2);

        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        wait_clear("clear_req_ignored", 1'b0, 100);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle(200);
        do_reset(2);
        wait_clear("clear_after_mid_reset", 1'b0, -1);
        cyc(1'b1, 1'b0, BASE, 32'h0, 1'b0);
        do_reset(1);
        wait_clear("clear_after_read_reset", 1'b0, -1);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
